// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU ops plus iterative signed mult/div
// writing the HI/LO pair, with a busy/done handshake towards the control FSM.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       selec,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   mb;
  logic               neg_q;
  logic               neg_r;
  logic               is_div;

  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   remd;

  assign amag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign bmag = b[WIDTH-1] ? (~b + 1'b1) : b;

  always_comb begin
    alu_res = '0;
    case (selec)
      3'd0:    alu_res = a + b;
      3'd1:    alu_res = a - b;
      3'd2:    alu_res = a | b;
      3'd3:    alu_res = a & b;
      3'd4:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // Multiply: acc holds the running upper half, shreg shifts the multiplier out
  // and the low product bits in. Divide: acc is the partial remainder, shreg
  // shifts dividend bits out and quotient bits in.
  assign mul_sum  = {1'b0, acc} + {1'b0, (shreg[0] ? mb : '0)};
  assign div_sh   = {acc, shreg[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, mb});
  assign div_sub  = div_sh[WIDTH-1:0] - mb;

  assign prod     = {acc, shreg};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign quot     = neg_q ? (~shreg + 1'b1) : shreg;
  assign remd     = neg_r ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      shreg  <= '0;
      mb     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy still high here means this is the done cycle of a mult/div
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            case (selec)
              3'd5: begin
                state  <= MUL;
                busy   <= 1'b1;
                cnt    <= '0;
                acc    <= '0;
                shreg  <= bmag;
                mb     <= amag;
                neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                is_div <= 1'b0;
              end
              3'd6: begin
                if (b == '0) begin
                  lo     <= '1;
                  hi     <= a;
                  result <= '1;
                  zero   <= 1'b0;
                  done   <= 1'b1;
                end else begin
                  state  <= DIV;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  acc    <= '0;
                  shreg  <= amag;
                  mb     <= bmag;
                  neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                  neg_r  <= a[WIDTH-1];
                  is_div <= 1'b1;
                end
              end
              3'd7: done <= 1'b1;
              default: begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                done   <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc   <= mul_sum[WIDTH:1];
          shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
          cnt   <= cnt + 6'd1;
          if (cnt == 6'(WIDTH-1)) begin
            state <= FIX;
            cnt   <= '0;
          end
        end
        DIV: begin
          acc   <= div_ge ? div_sub : div_sh[WIDTH-1:0];
          shreg <= {shreg[WIDTH-2:0], div_ge};
          cnt   <= cnt + 6'd1;
          if (cnt == 6'(WIDTH-1)) begin
            state <= FIX;
            cnt   <= '0;
          end
        end
        FIX: begin
          if (is_div) begin
            lo     <= quot;
            hi     <= remd;
            result <= quot;
            zero   <= (quot == '0);
          end else begin
            hi     <= prod_fix[2*WIDTH-1:WIDTH];
            lo     <= prod_fix[WIDTH-1:0];
            result <= prod_fix[WIDTH-1:0];
            zero   <= (prod_fix[WIDTH-1:0] == '0);
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
